// File: rtl/jimmy_io_pkg.sv
// jimmy_io_pkg: shared state encoding and status bit positions for the jimmy serial I/O blocks
package jimmy_io_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
endpackage

// File: rtl/jimmy_sync_fifo.sv
// jimmy_sync_fifo: circular byte FIFO with wrapping pointers and an occupancy count
module jimmy_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  // Storage needs no reset: emptiness is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end
  assign data_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == (AW+1)'(DEPTH);
endmodule

// File: rtl/jimmy_uart_tx.sv
// jimmy_uart_tx: strobe-driven byte FIFO feeding an 8N1 serial transmitter with a pollable status byte
module jimmy_uart_tx
  import jimmy_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_strobe_n,
  input  logic       clr_strobe_n,
  output logic       txd,
  output logic       busy,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] status
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t      state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           wr_q, clr_q, ovf_q, ovf_d;
  logic           wr_ev, clr_ev, push, pop, baud_done;
  logic [7:0]     fifo_dout;
  logic [CW-1:0]  fifo_count;
  assign wr_ev     = !wr_strobe_n && wr_q;
  assign clr_ev    = !clr_strobe_n && clr_q;
  // A pop on the same edge frees a slot, so a full FIFO can still take the byte.
  assign push      = wr_ev && (fifo_count != CW'(FIFO_DEPTH) || pop);
  assign ovf_d     = (wr_ev && !push) ? 1'b1 : clr_ev ? 1'b0 : ovf_q;
  assign baud_done = baud_q == BW'(CLKS_PER_BIT - 1);
  jimmy_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (wr_data),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
  always_comb begin
    state_d = state_q;
    baud_d  = baud_done ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          txd_d   = 1'b0;
          state_d = START;
        end
      end
      START: if (baud_done) begin
        state_d = DATA;
        txd_d   = shift_q[0];
        bit_d   = '0;
      end
      DATA: if (baud_done) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        txd_d   = (bit_q == 3'd7) ? 1'b1 : shift_q[1];
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (baud_done) begin
        pop     = !fifo_empty;
        shift_d = fifo_empty ? shift_q : fifo_dout;
        txd_d   = fifo_empty;
        state_d = fifo_empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      wr_q    <= 1'b1;
      clr_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      wr_q    <= wr_strobe_n;
      clr_q   <= clr_strobe_n;
      ovf_q   <= ovf_d;
    end
  end
  assign txd      = txd_q;
  assign busy     = state_q != IDLE;
  assign overflow = ovf_q;
  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = overflow;
  end
endmodule

// File: tb/tb_jimmy_uart_tx.sv
// tb_jimmy_uart_tx: scoreboard bench decoding txd frames against bytes the bench expects to be sent
module tb_jimmy_uart_tx;
  localparam int C = 4;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_strobe_n = 1'b1;
  logic       clr_strobe_n = 1'b1;
  logic       txd, busy, fifo_empty, fifo_full, overflow;
  logic [7:0] status;
  int         total = 0, bad = 0, frames = 0, n, f0, rx_cnt, k;
  bit         rx_on = 1'b0;
  logic [7:0] rx_sh;
  logic [7:0] exp_q [$];

  jimmy_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_strobe_n  (wr_strobe_n),
    .clr_strobe_n (clr_strobe_n),
    .txd          (txd),
    .busy         (busy),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .status       (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit acc, input bit clr);
    @(negedge clk);
    wr_data = d;
    wr_strobe_n = 1'b0;
    clr_strobe_n = !clr;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
    wr_strobe_n = 1'b1;
    clr_strobe_n = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    n = 0;
    while ((busy || !fifo_empty || rx_on) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < limit, 1);
  endtask

  // Line receiver: frame cycle 0 is the first negedge with txd low; samples mid-bit.
  initial forever begin
    @(negedge clk);
    if (!reset) rx_on = 1'b0;
    else if (!rx_on) begin
      if (txd === 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else rx_cnt++;
    if (rx_on) begin
      if (rx_cnt % C == C / 2) begin
        k = rx_cnt / C;
        if (k == 0) chk("start_bit", txd, 0);
        else if (k < 9) rx_sh[k-1] = txd;
        else chk("stop_bit", txd, 1);
      end
      if (rx_cnt == 10 * C - 1) begin
        rx_on = 1'b0;
        frames++;
        chk("frame_queued", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("rx_byte", rx_sh, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_status", status, 8'h01);
    chk("rst_busy", busy, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;

    wr(8'hA5, 1, 0);
    chk("txd_before_pop", txd, 1);
    chk("status_after_write", status, 8'h00);
    @(negedge clk);
    chk("start_latency", txd, 0);
    chk("busy_rise", busy, 1);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 40);
    chk("status_idle", status, 8'h01);

    wr(8'h00, 1, 0);
    wr(8'hFF, 1, 0);
    repeat (38) @(negedge clk);
    chk("b2b_stop", txd, 1);
    chk("b2b_not_empty", fifo_empty, 0);
    @(negedge clk);
    chk("b2b_no_gap", txd, 0);
    chk("b2b_empty", fifo_empty, 1);
    wait_idle(300);

    for (int i = 1; i <= 5; i++) wr(8'(i), 1, 0);
    wr(8'h06, 0, 0);
    chk("ovf_status", status, 8'h0E);
    chk("ovf_flag", overflow, 1);
    wr(8'h07, 0, 1);
    chk("ovf_set_wins", overflow, 1);
    @(negedge clk);
    clr_strobe_n = 1'b0;
    @(negedge clk);
    clr_strobe_n = 1'b1;
    chk("ovf_cleared", status, 8'h06);
    wait_idle(1000);

    f0 = frames;
    @(negedge clk);
    wr_data = 8'h3C;
    wr_strobe_n = 1'b0;
    exp_q.push_back(8'h3C);
    repeat (3) @(negedge clk);
    wr_strobe_n = 1'b1;
    wait_idle(300);
    chk("long_strobe_frames", frames, f0 + 1);

    wr(8'h10, 1, 0);
    for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i), 1, 0);
    chk("full_before", fifo_full, 1);
    repeat (31) @(negedge clk);
    wr(8'h15, 1, 0);
    chk("coinc_ovf", overflow, 0);
    chk("coinc_full", fifo_full, 1);
    chk("coinc_restart", txd, 0);
    wait_idle(1000);

    wr(8'h36, 1, 0);
    repeat (18) @(negedge clk);
    chk("bit3_low", txd, 0);
    #2;
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("async_txd", txd, 1);
    chk("async_status", status, 8'h01);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wr(8'hC3, 1, 0);
    wait_idle(300);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
